div_request_sequencer: RTL and testbench

//  Front-end for the unsigned slow divider. Accepts signed or unsigned divide requests

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_request_sequencer.sv | 135 +++++++++++++
 tb/tb_div_request_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sign helpers for the divide (and future multiply) front-ends.
// Helpers work at MAX_BITS; callers extend operands and keep the low bits.
package div_pkg;

   localparam int MAX_BITS = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } div_seq_state_t;

   function automatic logic [MAX_BITS-1:0] abs_mag(
      input logic [MAX_BITS-1:0] value,
      input logic                is_signed
   );
      return (is_signed && value[MAX_BITS-1]) ? -value : value;
   endfunction

   function automatic logic [MAX_BITS-1:0] neg_if(
      input logic [MAX_BITS-1:0] value,
      input logic                cond
   );
      return cond ? -value : value;
   endfunction

endpackage

// File: rtl/div_request_sequencer.sv
// Signed/unsigned request front-end for the unsigned slow divider:
// magnitude conversion, one-shot start, sign fix-up and response hold.
module div_request_sequencer
   import div_pkg::*;
#(
   parameter int DIVIDEND_BITS = 32,
   parameter int DIVISOR_BITS  = 32,
   parameter int TAG_BITS      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_signed,
   input  logic [DIVIDEND_BITS-1:0] req_dividend,
   input  logic [DIVISOR_BITS-1:0]  req_divisor,
   input  logic [TAG_BITS-1:0]      req_tag,
   input  logic                     flush,
   output logic                     div_start,
   output logic [DIVIDEND_BITS-1:0] div_dividend,
   output logic [DIVISOR_BITS-1:0]  div_divisor,
   input  logic [DIVIDEND_BITS-1:0] div_quotient,
   input  logic [DIVISOR_BITS-1:0]  div_remainder,
   input  logic                     div_done,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DIVIDEND_BITS-1:0] resp_quotient,
   output logic [DIVISOR_BITS-1:0]  resp_remainder,
   output logic                     resp_error,
   output logic [TAG_BITS-1:0]      resp_tag
);

   localparam int XD = MAX_BITS - DIVIDEND_BITS;
   localparam int XS = MAX_BITS - DIVISOR_BITS;

   div_seq_state_t r_state, w_next;

   logic [DIVIDEND_BITS-1:0] r_dvd_mag;
   logic [DIVISOR_BITS-1:0]  r_dvs_mag;
   logic                     r_dvd_neg;
   logic                     r_dvs_neg;
   logic [DIVIDEND_BITS-1:0] r_q;
   logic [DIVISOR_BITS-1:0]  r_r;
   logic                     r_err;
   logic [TAG_BITS-1:0]      r_tag;

   logic                w_accept;
   logic                w_dvs_zero;
   logic                w_capture;
   logic                w_dvd_sgn;
   logic                w_dvs_sgn;
   logic [MAX_BITS-1:0] w_dvd_abs;
   logic [MAX_BITS-1:0] w_dvs_abs;
   logic [MAX_BITS-1:0] w_q_fix;
   logic [MAX_BITS-1:0] w_r_fix;
   logic                w_unused;

   assign w_dvd_sgn = req_signed & req_dividend[DIVIDEND_BITS-1];
   assign w_dvs_sgn = req_signed & req_divisor[DIVISOR_BITS-1];

   // Sign-extend into the helper width so MIN maps to 2^(N-1) after truncation.
   assign w_dvd_abs = abs_mag({{XD{w_dvd_sgn}}, req_dividend}, req_signed);
   assign w_dvs_abs = abs_mag({{XS{w_dvs_sgn}}, req_divisor}, req_signed);
   assign w_q_fix   = neg_if({{XD{1'b0}}, div_quotient}, r_dvd_neg ^ r_dvs_neg);
   assign w_r_fix   = neg_if({{XS{1'b0}}, div_remainder}, r_dvd_neg);

   assign w_unused = ^{w_dvd_abs[MAX_BITS-1:DIVIDEND_BITS],
                       w_dvs_abs[MAX_BITS-1:DIVISOR_BITS],
                       w_q_fix[MAX_BITS-1:DIVIDEND_BITS],
                       w_r_fix[MAX_BITS-1:DIVISOR_BITS]};

   assign req_ready  = (r_state == IDLE) && !rst && !flush;
   assign w_accept   = req_valid && req_ready;
   assign w_dvs_zero = (req_divisor == '0);
   assign w_capture  = (r_state == WAIT) && div_done && !flush;

   assign div_start      = (r_state == ISSUE);
   assign div_dividend   = r_dvd_mag;
   assign div_divisor    = r_dvs_mag;
   assign resp_valid     = (r_state == RESP);
   assign resp_quotient  = r_q;
   assign resp_remainder = r_r;
   assign resp_error     = r_err;
   assign resp_tag       = r_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:  if (w_accept) w_next = w_dvs_zero ? RESP : ISSUE;
            ISSUE: w_next = WAIT;
            WAIT:  if (div_done) w_next = RESP;
            RESP:  if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dvd_mag <= '0;
         r_dvs_mag <= '0;
         r_dvd_neg <= 1'b0;
         r_dvs_neg <= 1'b0;
         r_q       <= '0;
         r_r       <= '0;
         r_err     <= 1'b0;
         r_tag     <= '0;
      end else if (w_accept) begin
         r_dvd_mag <= w_dvd_abs[DIVIDEND_BITS-1:0];
         r_dvs_mag <= w_dvs_abs[DIVISOR_BITS-1:0];
         r_dvd_neg <= w_dvd_sgn;
         r_dvs_neg <= w_dvs_sgn;
         r_tag     <= req_tag;
         r_err     <= w_dvs_zero;
         // Divide-by-zero bypasses the divider and answers directly.
         if (w_dvs_zero) begin
            r_q <= '1;
            r_r <= req_dividend[DIVISOR_BITS-1:0];
         end
      end else if (w_capture) begin
         r_q   <= w_q_fix[DIVIDEND_BITS-1:0];
         r_r   <= w_r_fix[DIVISOR_BITS-1:0];
         r_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_request_sequencer.sv
// Directed bench for div_request_sequencer with a behavioural
// fixed-latency unsigned divider next to it.
module tb_div_request_sequencer;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_signed = 1'b0;
   logic [31:0] req_dividend = '0;
   logic [31:0] req_divisor = '0;
   logic [3:0]  req_tag = '0;
   logic        flush = 1'b0;
   logic        div_start;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;
   logic        div_done = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_quotient;
   logic [31:0] resp_remainder;
   logic        resp_error;
   logic [3:0]  resp_tag;

   int n_chk = 0;
   int n_fail = 0;
   int n_start = 0;

   logic [31:0] m_q = '0;
   logic [31:0] m_r = '0;
   logic [31:0] st_dvd = '0;
   logic [31:0] st_dvs = '0;
   int          m_cnt = 0;
   logic        m_busy = 1'b0;

   always #5 clk = ~clk;

   div_request_sequencer #(
      .DIVIDEND_BITS(32),
      .DIVISOR_BITS (32),
      .TAG_BITS     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_signed    (req_signed),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .req_tag       (req_tag),
      .flush         (flush),
      .div_start     (div_start),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .div_done      (div_done),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_quotient (resp_quotient),
      .resp_remainder(resp_remainder),
      .resp_error    (resp_error),
      .resp_tag      (resp_tag)
   );

   assign div_quotient  = m_q;
   assign div_remainder = m_r;

   // Divider model: start sampled at one edge, done pulse N cycles later.
   always @(posedge clk) begin
      div_done <= 1'b0;
      if (div_start) begin
         m_q     <= div_dividend / div_divisor;
         m_r     <= div_dividend % div_divisor;
         st_dvd  <= div_dividend;
         st_dvs  <= div_divisor;
         m_cnt   <= N;
         m_busy  <= 1'b1;
         n_start <= n_start + 1;
      end else if (m_busy) begin
         if (m_cnt == 1) begin
            div_done <= 1'b1;
            m_busy   <= 1'b0;
         end
         m_cnt <= m_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_resp(input string nm, input int elat);
      int lat;
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, ".lat"}, 64'(lat), 64'(elat));
   endtask

   task automatic send(input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tg);
      @(negedge clk);
      req_signed   = sgn;
      req_dividend = a;
      req_divisor  = b;
      req_tag      = tg;
      req_valid    = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic take_resp(input string nm);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      chk({nm, ".drop"}, 64'(resp_valid), 64'd0);
   endtask

   task automatic check_div(
      input string nm, input logic sgn,
      input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
      input logic [31:0] eq, input logic [31:0] er, input logic ee,
      input int elat, input int estarts,
      input logic [31:0] emd, input logic [31:0] ems
   );
      int s0;
      s0 = n_start;
      @(negedge clk);
      chk({nm, ".rdy"}, 64'(req_ready), 64'd1);
      send(sgn, a, b, tg);
      wait_resp(nm, elat);
      chk({nm, ".q"},   64'(resp_quotient),  64'(eq));
      chk({nm, ".r"},   64'(resp_remainder), 64'(er));
      chk({nm, ".err"}, 64'(resp_error),     64'(ee));
      chk({nm, ".tag"}, 64'(resp_tag),       64'(tg));
      chk({nm, ".starts"}, 64'(n_start - s0), 64'(estarts));
      if (estarts != 0) begin
         chk({nm, ".mdvd"}, 64'(st_dvd), 64'(emd));
         chk({nm, ".mdvs"}, 64'(st_dvs), 64'(ems));
      end
      take_resp(nm);
   endtask

   initial begin
      int s0;
      logic seen;

      #3;
      chk("rst.ready", 64'(req_ready),     64'd0);
      chk("rst.valid", 64'(resp_valid),    64'd0);
      chk("rst.start", 64'(div_start),     64'd0);
      chk("rst.q",     64'(resp_quotient), 64'd0);
      chk("rst.err",   64'(resp_error),    64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("idle.ready", 64'(req_ready), 64'd1);

      check_div("u100_7", 1'b0, 32'd100, 32'd7, 4'd3,
                32'd14, 32'd2, 1'b0, N + 3, 1, 32'd100, 32'd7);
      check_div("uffff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 4'd1,
                32'h7FFF_FFFF, 32'd1, 1'b0, N + 3, 1,
                32'hFFFF_FFFF, 32'd2);
      check_div("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 4'd4,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, N + 3, 1,
                32'd7, 32'd2);
      check_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 4'd5,
                32'hFFFF_FFFD, 32'd1, 1'b0, N + 3, 1,
                32'd7, 32'd2);
      check_div("sm7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 4'd6,
                32'd3, 32'hFFFF_FFFF, 1'b0, N + 3, 1,
                32'd7, 32'd2);
      check_div("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7,
                32'h8000_0000, 32'd0, 1'b0, N + 3, 1,
                32'h8000_0000, 32'd1);
      check_div("div0", 1'b1, 32'h0000_1234, 32'd0, 4'd9,
                32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1, 0,
                32'd0, 32'd0);

      // Request coinciding with flush in IDLE is refused.
      s0 = n_start;
      @(negedge clk);
      flush        = 1'b1;
      req_valid    = 1'b1;
      req_signed   = 1'b0;
      req_dividend = 32'd1;
      req_divisor  = 32'd1;
      #1 chk("flushreq.ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("flushreq.starts", 64'(n_start - s0), 64'd0);
      chk("flushreq.valid",  64'(resp_valid),   64'd0);

      // Flush in WAIT; the stale done lands in IDLE and must be ignored.
      send(1'b0, 32'd50, 32'd5, 4'd2);
      repeat (6) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 seen = seen | resp_valid;
      end
      chk("flushwait.stale", 64'(seen), 64'd0);
      check_div("after_flush", 1'b0, 32'd9, 32'd3, 4'd8,
                32'd3, 32'd0, 1'b0, N + 3, 1, 32'd9, 32'd3);

      // Response held, then reset lands mid-RESP.
      send(1'b0, 32'd20, 32'd6, 4'd10);
      wait_resp("hold", N + 3);
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (!resp_valid || resp_quotient != 32'd3 ||
             resp_remainder != 32'd2 || resp_tag != 4'd10)
            seen = 1'b1;
      end
      chk("hold.stable", 64'(seen), 64'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst.valid", 64'(resp_valid), 64'd0);
      chk("midrst.ready", 64'(req_ready),  64'd0);
      chk("midrst.q",     64'(resp_quotient), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check_div("post_rst", 1'b0, 32'd21, 32'd4, 4'd12,
                32'd5, 32'd1, 1'b0, N + 3, 1, 32'd21, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
